// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared definitions for the VGA plotting blocks:
//            - the glyph blitter state encoding
//            - default screen limits (160x120 adapter)
//            - named 3-bit RGB colour constants
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } blit_state_t;

  localparam int XMAX_DEF = 159;
  localparam int YMAX_DEF = 119;

  // 3-bit colour is {R, G, B}
  localparam logic [2:0] c_col_black   = 3'b000;
  localparam logic [2:0] c_col_blue    = 3'b001;
  localparam logic [2:0] c_col_green   = 3'b010;
  localparam logic [2:0] c_col_cyan    = 3'b011;
  localparam logic [2:0] c_col_red     = 3'b100;
  localparam logic [2:0] c_col_magenta = 3'b101;
  localparam logic [2:0] c_col_yellow  = 3'b110;
  localparam logic [2:0] c_col_white   = 3'b111;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_blit_clip.sv
`default_nettype none
// ============================================================================
// Module   : vga_blit_clip
// Purpose  : Combinational pixel coordinate generator with screen clipping.
//            The base + offset sums are formed one bit wider than the screen
//            coordinates, so an overflowing sum is seen as off-screen instead
//            of wrapping back to the left or top edge.
// Ports    : i_base_x/i_base_y - top-left corner of the object
//            i_col/i_row       - offset inside the object
//            o_x/o_y           - truncated pixel coordinates
//            o_visible         - 1 when the wide sums lie inside the screen
// Revision : 1.0 - initial release
// ============================================================================
module vga_blit_clip
  import vga_pkg::*;
#(
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CLW  = 3,
  parameter int RW   = 3,
  parameter int XMAX = XMAX_DEF,
  parameter int YMAX = YMAX_DEF
) (
  input  logic [XW-1:0]  i_base_x,
  input  logic [YW-1:0]  i_base_y,
  input  logic [CLW-1:0] i_col,
  input  logic [RW-1:0]  i_row,
  output logic [XW-1:0]  o_x,
  output logic [YW-1:0]  o_y,
  output logic           o_visible
);

  localparam logic [XW:0] c_xmax = (XW+1)'(XMAX);
  localparam logic [YW:0] c_ymax = (YW+1)'(YMAX);

  logic [XW:0] w_x_wide;
  logic [YW:0] w_y_wide;

  assign w_x_wide  = (XW+1)'(i_base_x) + (XW+1)'(i_col);
  assign w_y_wide  = (YW+1)'(i_base_y) + (YW+1)'(i_row);
  assign o_x       = w_x_wide[XW-1:0];
  assign o_y       = w_y_wide[YW-1:0];
  assign o_visible = (w_x_wide <= c_xmax) && (w_y_wide <= c_ymax);

endmodule : vga_blit_clip
`default_nettype wire

// File: rtl/vga_glyph_blitter.sv
`default_nettype none
// ============================================================================
// Module   : vga_glyph_blitter
// Purpose  : Draws one GW x GH glyph per command as a stream of single-pixel
//            plot writes, fetching bitmap rows from a synchronous glyph ROM.
//            Supports transparent/opaque background and screen clipping.
// Ports    : clk, reset                - clock, async active-high reset
//            cmd_valid/cmd_ready       - command handshake (ready only in IDLE)
//            cmd_x/y/glyph/fg/bg/opaque- command fields, captured on accept
//            rom_addr/rom_data         - glyph ROM, data one cycle after addr
//            pix_x/y/colour/plot       - registered plot write to VGA adapter
//            busy                      - command in progress
//            done                      - one-cycle pulse after last pixel slot
// Revision : 1.0 - initial release
// ============================================================================
module vga_glyph_blitter
  import vga_pkg::*;
#(
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3,
  parameter int GW   = 8,
  parameter int GH   = 8,
  parameter int IW   = 5,
  parameter int XMAX = XMAX_DEF,
  parameter int YMAX = YMAX_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [XW-1:0]             cmd_x,
  input  logic [YW-1:0]             cmd_y,
  input  logic [IW-1:0]             cmd_glyph,
  input  logic [CW-1:0]             cmd_fg,
  input  logic [CW-1:0]             cmd_bg,
  input  logic                      cmd_opaque,
  output logic [IW+$clog2(GH)-1:0]  rom_addr,
  input  logic [GW-1:0]             rom_data,
  output logic [XW-1:0]             pix_x,
  output logic [YW-1:0]             pix_y,
  output logic [CW-1:0]             pix_colour,
  output logic                      pix_plot,
  output logic                      busy,
  output logic                      done
);

  localparam int RW  = $clog2(GH);
  localparam int CLW = (GW > 1) ? $clog2(GW) : 1;

  blit_state_t         r_state;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [IW-1:0]       r_glyph;
  logic [CW-1:0]       r_fg;
  logic [CW-1:0]       r_bg;
  logic                r_opaque;
  logic [RW-1:0]       r_row;
  logic [CLW-1:0]      r_col;
  logic [GW-1:0]       r_bits;
  logic [IW+RW-1:0]    r_rom_addr;
  logic [XW-1:0]       r_pix_x;
  logic [YW-1:0]       r_pix_y;
  logic [CW-1:0]       r_pix_colour;
  logic                r_pix_plot;
  logic                r_busy;
  logic                r_done;

  logic                w_accept;
  logic [XW-1:0]       w_x;
  logic [YW-1:0]       w_y;
  logic                w_visible;

  // Gated by reset so the CPU never sees ready while the block is held.
  assign cmd_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;

  vga_blit_clip #(
    .XW   (XW),
    .YW   (YW),
    .CLW  (CLW),
    .RW   (RW),
    .XMAX (XMAX),
    .YMAX (YMAX)
  ) u_clip (
    .i_base_x  (r_x),
    .i_base_y  (r_y),
    .i_col     (r_col),
    .i_row     (r_row),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_visible (w_visible)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_glyph      <= '0;
      r_fg         <= '0;
      r_bg         <= '0;
      r_opaque     <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_bits       <= '0;
      r_rom_addr   <= '0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_colour <= CW'(c_col_black);
      r_pix_plot   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_pix_plot <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x        <= cmd_x;
            r_y        <= cmd_y;
            r_glyph    <= cmd_glyph;
            r_fg       <= cmd_fg;
            r_bg       <= cmd_bg;
            r_opaque   <= cmd_opaque;
            r_row      <= '0;
            r_col      <= '0;
            // Address is loaded on entry to FETCH so the synchronous ROM
            // samples it at the end of FETCH and returns data during WAIT.
            r_rom_addr <= {cmd_glyph, RW'(0)};
            r_busy     <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_bits  <= rom_data;
          r_state <= ST_DRAW;
        end
        ST_DRAW: begin
          // The row register shifts left, so its MSB is always the pixel of
          // the current column (leftmost pixel first).
          r_pix_x      <= w_x;
          r_pix_y      <= w_y;
          r_pix_colour <= r_bits[GW-1] ? r_fg : r_bg;
          r_pix_plot   <= w_visible && (r_bits[GW-1] || r_opaque);
          r_bits       <= r_bits << 1;
          if (r_col == CLW'(GW-1)) begin
            if (r_row == RW'(GH-1)) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_row      <= r_row + RW'(1);
              r_col      <= '0;
              r_rom_addr <= {r_glyph, r_row + RW'(1)};
              r_state    <= ST_FETCH;
            end
          end else begin
            r_col <= r_col + CLW'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_addr   = r_rom_addr;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign pix_colour = r_pix_colour;
  assign pix_plot   = r_pix_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule : vga_glyph_blitter
`default_nettype wire

// File: tb/tb_vga_glyph_blitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_glyph_blitter
// Purpose  : Self-checking bench for vga_glyph_blitter. A reference model
//            expands each command into its expected plot stream, which is
//            queued and compared against the DUT's pixel outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_glyph_blitter;

  localparam int AW = 8;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [4:0] g;
    logic [2:0] fg;
    logic [2:0] bg;
    logic       op;
    int         exp_plots;
    string      name;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_x;
  logic [6:0]    cmd_y;
  logic [4:0]    cmd_glyph;
  logic [2:0]    cmd_fg;
  logic [2:0]    cmd_bg;
  logic          cmd_opaque;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [7:0]    pix_x;
  logic [6:0]    pix_y;
  logic [2:0]    pix_colour;
  logic          pix_plot;
  logic          busy;
  logic          done;

  logic [7:0]    rom [0:255];
  pix_t          sb[$];
  logic [AW-1:0] addr_log[$];
  logic [AW-1:0] last_addr;
  vec_t          vecs[8];
  int            n_pass = 0;
  int            n_total = 0;
  int            plot_cnt = 0;
  int            cyc = 0;
  bit            sb_en = 1'b1;

  vga_glyph_blitter dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_glyph  (cmd_glyph),
    .cmd_fg     (cmd_fg),
    .cmd_bg     (cmd_bg),
    .cmd_opaque (cmd_opaque),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .pix_plot   (pix_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every plot the DUT makes must match the head of the queue.
  always @(negedge clk) begin
    if (sb_en && !reset && pix_plot) begin
      plot_cnt++;
      chk("plot while busy", {31'd0, busy}, 32'd1);
      if (sb.size() == 0) begin
        chk("plot with empty scoreboard", {14'd0, pix_x, pix_y, pix_colour}, 32'hFFFF_FFFF);
      end else begin
        pix_t e;
        e = sb.pop_front();
        chk("pixel {x,y,colour}", {14'd0, pix_x, pix_y, pix_colour}, {14'd0, e});
      end
    end
  end

  task automatic push_model(input vec_t v);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        logic [7:0] bits;
        int xs, ys;
        pix_t p;
        bits = rom[{v.g, 3'(r)}];
        xs = int'(v.x) + c;
        ys = int'(v.y) + r;
        if (xs <= 159 && ys <= 119 && (bits[7-c] || v.op)) begin
          p.x = xs[7:0];
          p.y = ys[6:0];
          p.c = bits[7-c] ? v.fg : v.bg;
          sb.push_back(p);
        end
      end
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    cmd_x      = v.x;
    cmd_y      = v.y;
    cmd_glyph  = v.g;
    cmd_fg     = v.fg;
    cmd_bg     = v.bg;
    cmd_opaque = v.op;
    cmd_valid  = 1'b1;
  endtask

  task automatic wait_done(output int t_done, output bit ok);
    ok = 1'b0;
    t_done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rom_addr != last_addr) begin
        addr_log.push_back(rom_addr);
        last_addr = rom_addr;
      end
      if (done) begin
        t_done = cyc;
        ok = 1'b1;
        return;
      end
    end
    chk("done pulse timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int  t_acc, t_done;
    bit  ok;
    @(negedge clk);
    plot_cnt = 0;
    addr_log.delete();
    last_addr = rom_addr;
    drive_cmd(v);
    push_model(v);
    chk({v.name, " ready in idle"}, {31'd0, cmd_ready}, 32'd1);
    t_acc = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done(t_done, ok);
    if (ok) chk({v.name, " done latency"}, t_done - t_acc, 32'd81);
    @(negedge clk);
    chk({v.name, " done one cycle"}, {31'd0, done}, 32'd0);
    chk({v.name, " busy cleared"}, {31'd0, busy}, 32'd0);
    chk({v.name, " plot count"}, plot_cnt, v.exp_plots);
    chk({v.name, " scoreboard drained"}, sb.size(), 32'd0);
    chk({v.name, " fetch count"}, addr_log.size(), 32'd8);
    for (int r = 0; r < 8 && r < addr_log.size(); r++) begin
      logic [AW-1:0] ea;
      ea = {v.g, 3'(r)};
      chk({v.name, " rom_addr"}, {24'd0, addr_log[r]}, {24'd0, ea});
    end
  endtask

  initial begin
    int  t_a, t_da, t_b, t_db, rdy_seen, plot_seen, done_seen;
    bit  ok;
    vec_t va, vb, vr;

    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[3*8+0] = 8'b1000_0001;                       // glyph 3
    for (int r = 0; r < 8; r++) rom[5*8+r] = 8'hFF;  // glyph 5: solid
    for (int r = 0; r < 8; r++) rom[7*8+r] = r[0] ? 8'h55 : 8'hAA;
    for (int r = 0; r < 8; r++) rom[31*8+r] = 8'h01 << r;

    //           x       y      g      fg      bg      op    plots name
    vecs[0] = '{8'd10,  7'd20,  5'd3,  3'b011, 3'b100, 1'b0, 2,  "transparent"};
    vecs[1] = '{8'd10,  7'd20,  5'd3,  3'b011, 3'b100, 1'b1, 64, "opaque"};
    vecs[2] = '{8'd156, 7'd116, 5'd5,  3'b111, 3'b001, 1'b1, 16, "clip corner"};
    vecs[3] = '{8'd100, 7'd115, 5'd5,  3'b010, 3'b000, 1'b0, 40, "clip bottom"};
    vecs[4] = '{8'd250, 7'd0,   5'd5,  3'b110, 3'b001, 1'b1, 0,  "x overflow"};
    vecs[5] = '{8'd20,  7'd126, 5'd5,  3'b110, 3'b001, 1'b1, 0,  "y overflow"};
    vecs[6] = '{8'd0,   7'd0,   5'd7,  3'b110, 3'b001, 1'b0, 32, "checker"};
    vecs[7] = '{8'd152, 7'd112, 5'd31, 3'b101, 3'b000, 1'b0, 8,  "glyph 31"};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_glyph = '0; cmd_fg = '0; cmd_bg = '0; cmd_opaque = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pix_plot", {31'd0, pix_plot}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rom_addr", {24'd0, rom_addr}, 32'd0);
    chk("reset pix_x", {24'd0, pix_x}, 32'd0);
    chk("reset pix_y", {25'd0, pix_y}, 32'd0);
    chk("reset pix_colour", {29'd0, pix_colour}, 32'd0);
    reset = 1'b0;
    #1 chk("ready after reset", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Second command held on cmd_valid while the first one draws.
    va = '{8'd10, 7'd20, 5'd3, 3'b011, 3'b100, 1'b1, 64, "hs A"};
    vb = '{8'd30, 7'd40, 5'd5, 3'b010, 3'b000, 1'b0, 64, "hs B"};
    @(negedge clk);
    plot_cnt = 0;
    drive_cmd(va);
    push_model(va);
    t_a = cyc;
    @(posedge clk);
    @(negedge clk);
    drive_cmd(vb);
    push_model(vb);
    rdy_seen = 0;
    t_da = 0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (cmd_ready) rdy_seen++;
      if (done) begin ok = 1'b1; t_da = cyc; end
      else @(negedge clk);
    end
    chk("hs A done seen", {31'd0, ok}, 32'd1);
    chk("hs ready low while busy", rdy_seen, 32'd0);
    chk("hs A latency", t_da - t_a, 32'd81);
    @(negedge clk);
    chk("hs ready in idle after done", {31'd0, cmd_ready}, 32'd1);
    t_b = cyc;
    chk("hs B accepted right after done", t_b - t_da, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("hs B busy", {31'd0, busy}, 32'd1);
    wait_done(t_db, ok);
    if (ok) chk("hs B latency", t_db - t_b, 32'd81);
    @(negedge clk);
    chk("hs plot count", plot_cnt, 32'd128);
    chk("hs scoreboard drained", sb.size(), 32'd0);

    // Reset while drawing row 4, column 3.
    sb_en = 1'b0;
    vr = '{8'd0, 7'd0, 5'd5, 3'b111, 3'b001, 1'b1, 64, "reset run"};
    @(negedge clk);
    drive_cmd(vr);
    t_a = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cyc - t_a >= 46) break;
    end
    chk("pre-reset plot active", {31'd0, pix_plot}, 32'd1);
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset pix_plot", {31'd0, pix_plot}, 32'd0);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset done", {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    plot_seen = 0;
    done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pix_plot) plot_seen++;
      if (done) done_seen++;
    end
    chk("no plots after reset", plot_seen, 32'd0);
    chk("no done after reset", done_seen, 32'd0);
    chk("ready after mid-draw reset", {31'd0, cmd_ready}, 32'd1);
    sb.delete();
    sb_en = 1'b1;

    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_vga_glyph_blitter
`default_nettype wire
